flash_responder: RTL and testbench

FLASH_RESPONDER -- requirements
Module: flash_responder

---
 rtl/flash_responder.sv | 183 ++++++++++++++++++
 tb/tb_flash_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_responder.sv
// rtl/flash_responder.sv - Single-beat flash read responder with wait states and a fixed-latency return pipeline
//
// Purpose:
//    Answers single-word reads on a memory-mapped command port from an internal
//    word store that is filled through a separate preload port. Each read is
//    stalled for WAIT_CYCLES extra cycles before it is accepted, and its word is
//    returned READ_LATENCY cycles after acceptance. At most MAX_PENDING reads
//    may be accepted but not yet returned. Writes are not supported and only
//    raise the sticky error flag.
//
// Ports:
//    clk, rst                   clock, synchronous active-high reset
//    flash_mem_read/write       command strobes (write is refused as an error)
//    flash_mem_address          23-bit word address
//    flash_mem_writedata        ignored
//    flash_mem_byteenable       expected 4'b1111, otherwise error
//    flash_mem_burstcount       expected 1, otherwise error
//    flash_mem_waitrequest      high when the command is not taken this cycle
//    flash_mem_readdata         returned word, zero when not valid
//    flash_mem_readdatavalid    one-cycle return strobe
//    load_en/load_addr/load_data  preload write port into the store
//    err                        sticky protocol-error flag
//    rd_count                   saturating count of accepted reads

module flash_responder #(
   parameter int DEPTH_W      = 8,
   parameter int WAIT_CYCLES  = 2,
   parameter int READ_LATENCY = 3,
   parameter int MAX_PENDING  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flash_mem_read,
   input  logic               flash_mem_write,
   input  logic [22:0]        flash_mem_address,
   input  logic [31:0]        flash_mem_writedata,
   input  logic [3:0]         flash_mem_byteenable,
   input  logic               flash_mem_burstcount,
   output logic               flash_mem_waitrequest,
   output logic [31:0]        flash_mem_readdata,
   output logic               flash_mem_readdatavalid,
   input  logic               load_en,
   input  logic [DEPTH_W-1:0] load_addr,
   input  logic [31:0]        load_data,
   output logic               err,
   output logic [15:0]        rd_count
);

   localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int WORDS  = 1 << DEPTH_W;
   localparam int LAST   = READ_LATENCY - 1;

   typedef enum logic {IDLE, STALL} state_t;

   state_t                  state_q, state_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [PEND_W-1:0]       pend_q, pend_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [31:0]             dat_q [READ_LATENCY];
   logic [31:0]             dat_d [READ_LATENCY];
   logic                    err_q, err_d;
   logic [15:0]             cnt_q, cnt_d;

   logic [31:0]             store [WORDS];

   logic                    waitreq_c;
   logic                    accept;
   logic                    in_range;
   logic [31:0]             rd_word;
   logic                    unused_writedata;

   assign unused_writedata = ^flash_mem_writedata;

   // Any address bit above the store index makes the access out of range.
   assign in_range = (flash_mem_address >> DEPTH_W) == 23'd0;
   // Combinational read: a same-cycle preload to this index lands at the
   // edge, so the accepted read still sees the old word.
   assign rd_word  = in_range ? store[flash_mem_address[DEPTH_W-1:0]] : 32'h0;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      waitreq_c = 1'b1;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (flash_mem_read) begin
               state_d = STALL;
               wcnt_d  = WCNT_W'(WAIT_CYCLES);
            end else if (flash_mem_write) begin
               // Write is taken off the bus but never touches the store.
               waitreq_c = 1'b0;
               err_d     = 1'b1;
            end
         end
         STALL: begin
            if (!flash_mem_read) begin
               // Master abandoned the read while stalled.
               err_d   = 1'b1;
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else if (pend_q < PEND_W'(MAX_PENDING)) begin
               waitreq_c = 1'b0;
               accept    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flash_mem_read && flash_mem_write) begin
         err_d = 1'b1;
      end
      if (accept && (!in_range || flash_mem_byteenable != 4'hF || flash_mem_burstcount != 1'b1)) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      vld_d[0] = accept;
      dat_d[0] = accept ? rd_word : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end

      pend_d = pend_q;
      if (accept && !vld_q[LAST]) begin
         pend_d = pend_q + 1'b1;
      end else if (!accept && vld_q[LAST]) begin
         pend_d = pend_q - 1'b1;
      end

      cnt_d = cnt_q;
      if (accept && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         pend_q  <= '0;
         vld_q   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dat_q[i] <= 32'h0;
         end
         err_q   <= 1'b0;
         cnt_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pend_q  <= pend_d;
         vld_q   <= vld_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dat_q[i] <= dat_d[i];
         end
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Store contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (load_en) begin
         store[load_addr] <= load_data;
      end
   end

   // Reset masks the bus outputs immediately, before the registers clear.
   assign flash_mem_waitrequest   = rst | waitreq_c;
   assign flash_mem_readdatavalid = vld_q[LAST] & ~rst;
   assign flash_mem_readdata      = flash_mem_readdatavalid ? dat_q[LAST] : 32'h0;
   assign err                     = err_q;
   assign rd_count                = cnt_q;

endmodule

// File: tb/tb_flash_responder.sv
// tb/tb_flash_responder.sv - Self-checking bench for flash_responder

module tb_flash_responder;

   localparam int WC = 2;
   localparam int RL = 3;
   localparam int MP = 2;

   logic        clk, rst;
   logic        read, write, bc, load_en;
   logic [22:0] addr;
   logic [31:0] wdata, load_data;
   logic [3:0]  be;
   logic [7:0]  load_addr;
   logic        wreq0, rdv0, err0;
   logic [31:0] rd0;
   logic [15:0] rdcnt0;

   logic        b_read, b_write, b_bc;
   logic [22:0] b_addr;
   logic [31:0] b_wdata;
   logic [3:0]  b_be;
   logic        b_wreq, b_rdv, b_err;
   logic [31:0] b_rdata;
   logic [15:0] b_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit rand_load = 0;
   bit m_err;
   int m_cnt;

   typedef struct {
      logic [31:0] data;
      int          due;
   } ret_t;
   ret_t exp_q[$];
   int   due_hist[$];
   logic [31:0] mstore [256];

   typedef struct {
      logic [22:0] a;
      logic [3:0]  be;
      logic        bc;
      logic        wr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vt[8];

   flash_responder u0 (
      .clk(clk), .rst(rst),
      .flash_mem_read(read), .flash_mem_write(write),
      .flash_mem_address(addr), .flash_mem_writedata(wdata),
      .flash_mem_byteenable(be), .flash_mem_burstcount(bc),
      .flash_mem_waitrequest(wreq0), .flash_mem_readdata(rd0),
      .flash_mem_readdatavalid(rdv0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .err(err0), .rd_count(rdcnt0)
   );

   flash_responder #(.WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(1)) u1 (
      .clk(clk), .rst(rst),
      .flash_mem_read(b_read), .flash_mem_write(b_write),
      .flash_mem_address(b_addr), .flash_mem_writedata(b_wdata),
      .flash_mem_byteenable(b_be), .flash_mem_burstcount(b_bc),
      .flash_mem_waitrequest(b_wreq), .flash_mem_readdata(b_rdata),
      .flash_mem_readdatavalid(b_rdv),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .err(b_err), .rd_count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (load_en) mstore[load_addr] <= load_data;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Return checker: every valid must match the oldest outstanding read, on time.
   always @(negedge clk) begin : mon
      ret_t e;
      if (rst) begin
         exp_q.delete();
      end else if (rdv0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid cyc=%0d got=%h", cyc, rd0);
         end else begin
            e = exp_q.pop_front();
            if (e.data !== rd0 || e.due != cyc) begin
               bad++;
               $display("FAIL return got=%h@%0d exp=%h@%0d", rd0, cyc, e.data, e.due);
            end
         end
      end else begin
         total++;
         if (rd0 !== 32'h0) begin
            bad++;
            $display("FAIL rdata_idle got=%h exp=0", rd0);
         end
         if (exp_q.size() > 0) begin
            total++;
            if (exp_q[0].due < cyc) begin
               bad++;
               $display("FAIL missing_valid exp=%h due=%0d", exp_q[0].data, exp_q[0].due);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_load) begin
         load_en   = 1'($urandom_range(0, 1));
         load_addr = 8'($urandom);
         load_data = $urandom;
      end else begin
         load_en = 1'b0;
      end
   endtask

   function automatic int pend_at(input int t);
      int n = 0;
      foreach (due_hist[i]) if (due_hist[i] >= t) n++;
      return n;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      read = 1'b0; write = 1'b0; be = 4'hF; bc = 1'b1;
      b_read = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_waitreq", wreq0, 1);
      chk("rst_valid", rdv0, 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_err", err0, 0);
      chk("rst_count", rdcnt0, 0);
      tick();
      rst = 1'b0;
      due_hist.delete();
      m_err = 0;
      m_cnt = 0;
   endtask

   task automatic do_read(input logic [22:0] a, input logic [3:0] bev, input logic bcv,
                          input logic wr, input bit hold, output int acc);
      int t;
      bit ok;
      ret_t e;
      read = 1'b1; addr = a; be = bev; bc = bcv; write = wr; wdata = $urandom;
      t = cyc + WC + 1;
      while (pend_at(t) >= MP) t++;
      ok = 0;
      acc = -1;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (!wreq0) begin
            ok = 1;
            acc = cyc;
         end else begin
            tick();
         end
      end
      chk_int("accept_cycle", acc, t);
      if (ok) begin
         e.data = ((a >> 8) != 23'd0) ? 32'h0 : mstore[a[7:0]];
         e.due  = acc + RL;
         exp_q.push_back(e);
         due_hist.push_back(acc + RL);
         m_cnt++;
         if (wr || bev != 4'hF || bcv !== 1'b1 || (a >> 8) != 23'd0) m_err = 1;
      end
      tick();
      if (!hold) read = 1'b0;
      write = 1'b0; be = 4'hF; bc = 1'b1;
   endtask

   task automatic wait_ret(output logic [31:0] d, output int c);
      bit got = 0;
      c = -1;
      d = 32'hx;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (rdv0) begin
            d = rd0;
            c = cyc;
            got = 1;
         end
         tick();
      end
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
      chk_int("drain_left", exp_q.size(), 0);
   endtask

   initial begin : main
      int          acc, c;
      logic [31:0] d;
      bit          ew[9];
      bit          ev[9];
      int          gap;
      logic [22:0] ra;
      logic [3:0]  rbe;

      vt[0] = '{23'd5,        4'hF, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0};
      vt[1] = '{23'd0,        4'hF, 1'b1, 1'b0, 32'hC0DE_0000, 1'b0};
      vt[2] = '{23'd255,      4'hF, 1'b1, 1'b0, 32'hC0DE_00FF, 1'b0};
      vt[3] = '{23'h000100,   4'hF, 1'b1, 1'b0, 32'h0,         1'b1};
      vt[4] = '{23'd7,        4'h3, 1'b1, 1'b0, 32'hC0DE_0007, 1'b1};
      vt[5] = '{23'd9,        4'hF, 1'b0, 1'b0, 32'hC0DE_0009, 1'b1};
      vt[6] = '{23'd12,       4'hF, 1'b1, 1'b1, 32'hC0DE_000C, 1'b1};
      vt[7] = '{23'h7FFFFF,   4'hF, 1'b1, 1'b0, 32'h0,         1'b1};
      ew = '{1, 0, 1, 1, 1, 0, 1, 1, 1};
      ev = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

      rst = 1'b1;
      read = 0; write = 0; addr = 0; wdata = 0; be = 4'hF; bc = 1'b1;
      b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 4'hF; b_bc = 1'b1;
      load_en = 0; load_addr = 0; load_data = 0;
      m_err = 0; m_cnt = 0;

      for (int i = 0; i < 256; i++) begin
         load_en = 1'b1; load_addr = 8'(i); load_data = 32'hC0DE_0000 + 32'(i);
         @(posedge clk); #1;
      end
      load_en = 1'b1; load_addr = 8'd5; load_data = 32'hA5A5_0001;
      tick();

      do_reset();

      // Table of single reads, each from a clean reset.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         do_read(vt[i].a, vt[i].be, vt[i].bc, vt[i].wr, 0, acc);
         wait_ret(d, c);
         chk("tbl_data", d, vt[i].exp_data);
         chk_int("tbl_latency", c, acc + RL);
         @(negedge clk);
         chk("tbl_err", err0, vt[i].exp_err);
         chk("tbl_count", rdcnt0, 1);
         tick();
      end

      // Zero-wait, single-pending build: stall until the first return lands.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         b_read = (i <= 5);
         b_addr = (i <= 1) ? 23'd5 : 23'd6;
         @(negedge clk);
         chk("z_waitreq", b_wreq, 32'(ew[i]));
         chk("z_valid", b_rdv, 32'(ev[i]));
         chk("z_rdata", b_rdata, (i == 4) ? 32'hA5A5_0001 : (i == 8) ? 32'hC0DE_0006 : 32'h0);
         tick();
      end
      chk("z_err", b_err, 0);
      chk("z_count", b_cnt, 2);

      // Write in idle: taken, store untouched, error sticks.
      do_reset();
      write = 1'b1; addr = 23'd5; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_waitreq", wreq0, 0);
      tick();
      write = 1'b0;
      @(negedge clk);
      chk("wr_err", err0, 1);
      m_err = 1;
      repeat (5) tick();
      do_read(23'd5, 4'hF, 1'b1, 1'b0, 0, acc);
      wait_ret(d, c);
      chk("wr_store_kept", d, 32'hA5A5_0001);
      @(negedge clk);
      chk("wr_err_sticky", err0, 1);
      tick();

      // Read abandoned during stall.
      do_reset();
      read = 1'b1; addr = 23'd3;
      tick();
      read = 1'b0;
      @(negedge clk);
      chk("abandon_waitreq", wreq0, 1);
      tick();
      @(negedge clk);
      chk("abandon_err", err0, 1);
      chk("abandon_count", rdcnt0, 0);
      repeat (6) tick();
      m_err = 1;
      do_read(23'd3, 4'hF, 1'b1, 1'b0, 0, acc);
      wait_drain();

      // Held read across three addresses, returns in order.
      do_reset();
      do_read(23'd0, 4'hF, 1'b1, 1'b0, 1, acc);
      do_read(23'd1, 4'hF, 1'b1, 1'b0, 1, acc);
      do_read(23'd2, 4'hF, 1'b1, 1'b0, 0, acc);
      wait_drain();
      @(negedge clk);
      chk("held_count", rdcnt0, 3);
      tick();

      // Reset one cycle after an accept drops the return.
      do_reset();
      do_read(23'd5, 4'hF, 1'b1, 1'b0, 0, acc);
      do_reset();
      repeat (8) tick();
      do_read(23'd5, 4'hF, 1'b1, 1'b0, 0, acc);
      wait_ret(d, c);
      chk("post_rst_store", d, 32'hA5A5_0001);

      // Randomized traffic with concurrent preloads against the model.
      do_reset();
      rand_load = 1;
      for (int i = 0; i < 200; i++) begin
         gap = $urandom_range(0, 3);
         ra  = ($urandom_range(0, 9) == 0) ? 23'($urandom) : 23'($urandom_range(0, 255));
         rbe = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
         do_read(ra, rbe, 1'b1, 1'b0, (gap == 0), acc);
         repeat (gap) tick();
      end
      read = 1'b0;
      wait_drain();
      rand_load = 0;
      tick();
      @(negedge clk);
      chk("rand_err", err0, 32'(m_err));
      chk("rand_count", rdcnt0, (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
